// File: rtl/cache_line_arbiter_pkg.sv
// rtl/cache_line_arbiter_pkg.sv - shared types for the I/D cacheline memory-port arbiter
package cache_line_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } arb_side_t;

  // Two-way round-robin: a lone requester wins; on a tie the side not granted last wins.
  function automatic arb_side_t rr_pick2(input logic i_req, input logic d_req,
                                         input arb_side_t last);
    if (d_req && (!i_req || last == SIDE_I)) return SIDE_D;
    return SIDE_I;
  endfunction

endpackage

// File: rtl/cache_line_arbiter.sv
// rtl/cache_line_arbiter.sv - shares one line-wide memory port between I-cache and D-cache misses
module cache_line_arbiter
  import cache_line_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t        state_q, state_d;
  arb_side_t         last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [LINE_W-1:0] req_wdata_q, req_wdata_d;
  logic              req_is_write_q, req_is_write_d;

  logic      i_req, d_req;
  arb_side_t pick;

  assign i_req = i_read;
  assign d_req = d_read | d_write;
  assign pick  = rr_pick2(i_req, d_req, last_grant_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      last_grant_q   <= SIDE_D;
      req_addr_q     <= '0;
      req_wdata_q    <= '0;
      req_is_write_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      req_addr_q     <= req_addr_d;
      req_wdata_q    <= req_wdata_d;
      req_is_write_q <= req_is_write_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    req_addr_d     = req_addr_q;
    req_wdata_d    = req_wdata_q;
    req_is_write_d = req_is_write_q;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    i_resp         = 1'b0;
    d_resp         = 1'b0;

    case (state_q)
      IDLE: begin
        // mem_resp is deliberately not looked at here: stale or spurious responses are dropped.
        if (i_req || d_req) begin
          last_grant_d = pick;
          if (pick == SIDE_I) begin
            state_d        = SERVE_I;
            req_addr_d     = i_addr;
            req_is_write_d = 1'b0;
          end else begin
            state_d        = SERVE_D;
            req_addr_d     = d_addr;
            req_wdata_d    = d_wdata;
            req_is_write_d = d_write;
          end
        end
      end
      SERVE_I: begin
        mem_read = 1'b1;
        if (mem_resp) begin
          i_resp  = 1'b1;
          state_d = IDLE;
        end
      end
      SERVE_D: begin
        mem_read  = !req_is_write_q;
        mem_write = req_is_write_q;
        if (mem_resp) begin
          d_resp  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr  = req_addr_q;
  assign mem_wdata = req_wdata_q;
  assign i_rdata   = mem_rdata;
  assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_cache_line_arbiter.sv
// tb/tb_cache_line_arbiter.sv - scoreboard bench for cache_line_arbiter
module tb_cache_line_arbiter;
  import cache_line_arbiter_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int LINE_W  = 256;
  localparam int MEM_LAT = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  logic              mem_auto;
  logic              man_resp;
  logic              fill_mode;
  logic [LINE_W-1:0] mem_fill;

  typedef struct {
    bit                is_d;
    bit                chk;
    logic [LINE_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  cache_line_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  // Memory model: answers on the MEM_LAT-th cycle of a held strobe, or replays man_resp.
  initial begin
    int cnt;
    cnt = 0;
    mem_resp = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_resp = 1'b0;
      if (!mem_auto) begin
        mem_resp = man_resp;
        mem_rdata = mem_fill;
        cnt = 0;
      end else if (mem_read || mem_write) begin
        cnt++;
        if (cnt == MEM_LAT) begin
          mem_resp = 1'b1;
          mem_rdata = fill_mode ? {(LINE_W/ADDR_W){mem_addr}} : mem_fill;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(input int budget);
    exp_t e;
    bit   got;
    got = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (i_resp || d_resp) begin
        got = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!got) begin
      tests_failed++;
      $display("FAIL resp_timeout: no i_resp/d_resp within %0d cycles", budget);
      return;
    end
    if (i_resp && d_resp) begin
      tests_failed++;
      $display("FAIL resp_both: i_resp=%b d_resp=%b required exactly one", i_resp, d_resp);
    end
    tests_run++;
    if (exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL resp_unexpected: i_resp=%b d_resp=%b with empty scoreboard", i_resp, d_resp);
      return;
    end
    e = exp_q.pop_front();
    if (d_resp !== e.is_d) begin
      tests_failed++;
      $display("FAIL resp_side: d_resp=%b i_resp=%b required d_resp=%b", d_resp, i_resp, e.is_d);
    end
    if (e.chk) begin
      tests_run++;
      if ((e.is_d ? d_rdata : i_rdata) !== e.data) begin
        tests_failed++;
        $display("FAIL resp_data: got %h required %h", e.is_d ? d_rdata : i_rdata, e.data);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    tests_run++;
    if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_strobes: rd=%b wr=%b iresp=%b dresp=%b required 0",
               mem_read, mem_write, i_resp, d_resp);
    end
    tests_run++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      tests_failed++;
      $display("FAIL reset_addr_wdata: addr=%h wdata=%h required 0", mem_addr, mem_wdata);
    end
  endtask

  task automatic test_tie;
    exp_t e;
    fill_mode = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_read = 1'b1;
    d_read = 1'b1;
    i_addr = 32'h0000_0100;
    d_addr = 32'h0000_0200;
    for (int k = 0; k < 4; k++) begin
      e.is_d = (k % 2) == 1;
      e.chk  = 1'b1;
      e.data = {(LINE_W/ADDR_W){e.is_d ? d_addr : i_addr}};
      exp_q.push_back(e);
    end
    for (int k = 0; k < 4; k++) wait_resp(20);
    tick();
    i_read = 1'b0;
    d_read = 1'b0;
    tick();
    fill_mode = 1'b0;
  endtask

  task automatic test_i_only;
    exp_t e;
    mem_fill = {(LINE_W/8){8'hA5}};
    i_read = 1'b1;
    i_addr = 32'h0000_0040;
    e.is_d = 1'b0; e.chk = 1'b1; e.data = {(LINE_W/8){8'hA5}};
    exp_q.push_back(e);
    @(negedge clk);
    tests_run++;
    if (mem_read !== 1'b0) begin
      tests_failed++;
      $display("FAIL i_latency_early: mem_read=%b required 0 in request cycle", mem_read);
    end
    @(negedge clk);
    tests_run++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h40) begin
      tests_failed++;
      $display("FAIL i_grant: rd=%b wr=%b addr=%h required 1 0 00000040", mem_read, mem_write, mem_addr);
    end
    wait_resp(20);
    tick();
    i_read = 1'b0;
    @(negedge clk);
    tests_run++;
    if (i_resp !== 1'b0 || d_resp !== 1'b0 || mem_read !== 1'b0) begin
      tests_failed++;
      $display("FAIL i_pulse_width: iresp=%b dresp=%b rd=%b required 0", i_resp, d_resp, mem_read);
    end
  endtask

  task automatic test_d_writeback;
    exp_t e;
    logic [LINE_W-1:0] wd;
    wd = {(LINE_W/32){32'h1234_5678}};
    d_write = 1'b1;
    d_addr  = 32'h0000_1000;
    d_wdata = wd;
    e.is_d = 1'b1; e.chk = 1'b0; e.data = '0;
    exp_q.push_back(e);
    tick();
    d_addr  = 32'hFFFF_FFE0;
    d_wdata = ~wd;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      tests_run++;
      if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 32'h1000 ||
          mem_wdata !== wd || d_resp !== 1'b0) begin
        tests_failed++;
        $display("FAIL wb_hold: wr=%b rd=%b addr=%h dresp=%b wdata_ok=%b required 1 0 00001000 0 1",
                 mem_write, mem_read, mem_addr, d_resp, mem_wdata === wd);
      end
    end
    wait_resp(20);
    tests_run++;
    if (mem_write !== 1'b1 || mem_addr !== 32'h1000) begin
      tests_failed++;
      $display("FAIL wb_at_resp: wr=%b addr=%h required 1 00001000", mem_write, mem_addr);
    end
    tick();
    d_write = 1'b0;
    tick();
  endtask

  task automatic test_rw_both;
    exp_t e;
    d_read  = 1'b1;
    d_write = 1'b1;
    d_addr  = 32'h0000_0300;
    e.is_d = 1'b1; e.chk = 1'b0; e.data = '0;
    exp_q.push_back(e);
    tick();
    @(negedge clk);
    tests_run++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0) begin
      tests_failed++;
      $display("FAIL rw_both: wr=%b rd=%b required 1 0", mem_write, mem_read);
    end
    wait_resp(20);
    tick();
    d_read  = 1'b0;
    d_write = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    mem_auto = 1'b0;
    man_resp = 1'b0;
    mem_fill = {(LINE_W/8){8'h3C}};
    d_read = 1'b1;
    d_addr = 32'h0000_0400;
    tick();
    @(negedge clk);
    tests_run++;
    if (mem_read !== 1'b1) begin
      tests_failed++;
      $display("FAIL rm_serving: mem_read=%b required 1 before reset", mem_read);
    end
    tick();
    rst = 1'b1;
    d_read = 1'b0;
    tick();
    rst = 1'b0;
    man_resp = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({mem_read, mem_write, i_resp, d_resp} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL rm_after_reset: rd=%b wr=%b iresp=%b dresp=%b required 0",
               mem_read, mem_write, i_resp, d_resp);
    end
    tick();
    man_resp = 1'b0;
    @(negedge clk);
    tests_run++;
    if (dut.state_q !== IDLE || d_resp !== 1'b0) begin
      tests_failed++;
      $display("FAIL rm_state: state=%0d dresp=%b required IDLE 0", dut.state_q, d_resp);
    end
  endtask

  task automatic test_spurious;
    mem_auto = 1'b0;
    man_resp = 1'b1;
    @(negedge clk);
    tests_run++;
    if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
      tests_failed++;
      $display("FAIL spurious_resp: iresp=%b dresp=%b required 0", i_resp, d_resp);
    end
    tick();
    man_resp = 1'b0;
    @(negedge clk);
    tests_run++;
    if (dut.state_q !== IDLE || mem_read !== 1'b0 || mem_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL spurious_state: state=%0d rd=%b wr=%b required IDLE 0 0",
               dut.state_q, mem_read, mem_write);
    end
    mem_auto = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back;
    exp_t e;
    d_read = 1'b1;
    d_addr = 32'h0000_0800;
    mem_fill = {(LINE_W/8){8'h5A}};
    e.is_d = 1'b1; e.chk = 1'b1; e.data = {(LINE_W/8){8'h5A}};
    exp_q.push_back(e);
    wait_resp(20);
    tick();
    d_read = 1'b0;
    i_read = 1'b1;
    i_addr = 32'h0000_0840;
    e.is_d = 1'b0; e.chk = 1'b1; e.data = {(LINE_W/8){8'h5A}};
    exp_q.push_back(e);
    wait_resp(20);
    tick();
    i_read = 1'b0;
    tick();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    i_read = 1'b0; i_addr = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    mem_auto = 1'b1; man_resp = 1'b0; fill_mode = 1'b0; mem_fill = '0;
    test_reset();
    test_tie();
    test_i_only();
    test_d_writeback();
    test_rw_both();
    test_reset_mid();
    test_spurious();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/cache_line_arbiter.md
Name: cache_line_arbiter

Overview:
- Shares the single physical-memory (L2/cacheline adaptor) port between the instruction-cache miss path and the data-cache miss/writeback path.
- Sits below the IF and MA stages. Their stall signals remain asserted until this block returns resp for the stage's line transfer.
- Round-robin on ties; one transaction in flight at a time.

Parameters:
- ADDR_W, 32, byte address width
- LINE_W, 256, cache line width in bits

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_read  in  1  I-cache line read request (level, held until i_resp)
- i_addr  in  ADDR_W  I-cache line address
- i_rdata  out  LINE_W  line returned to I-cache
- i_resp  out  1  one-cycle completion pulse to I-cache
- d_read  in  1  D-cache line read request (level)
- d_write  in  1  D-cache line writeback request (level)
- d_addr  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  writeback line data
- d_rdata  out  LINE_W  line returned to D-cache
- d_resp  out  1  one-cycle completion pulse to D-cache
- mem_read  out  1  memory read strobe (level until mem_resp)
- mem_write  out  1  memory write strobe (level until mem_resp)
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  LINE_W  memory write data
- mem_rdata  in  LINE_W  memory read data, valid with mem_resp
- mem_resp  in  1  memory completion pulse

Behaviour:
- States:
  - IDLE: no transaction in flight.
  - SERVE_I: serving an I-cache read.
  - SERVE_D: serving a D-cache read or writeback.
- Registers:
  - state
  - last_grant (0=I, 1=D)
  - req_addr
  - req_wdata
  - req_is_write
- Reset values:
  - state=IDLE
  - last_grant=D, so I wins the first tie
  - req_addr=0, req_wdata=0, req_is_write=0
  - All outputs 0.
- IDLE arbitration (evaluated every IDLE cycle):
  - i_req = i_read; d_req = d_read|d_write.
  - Only one requesting: grant it.
  - Both requesting: grant the side not equal to last_grant.
  - On grant:
    - Latch address, wdata and write flag (d_write).
    - Set last_grant.
    - Go to SERVE_x next cycle.
- Grant latency: a request sampled in IDLE at cycle N drives mem_read/mem_write from cycle N+1.
- Output driving:
  - mem_addr, mem_wdata, mem_read and mem_write come from latched registers only.
  - Requester inputs changing during SERVE_x have no effect.
- SERVE_I:
  - mem_read=1, mem_write=0.
  - On mem_resp: i_resp=1 (combinational, same cycle), i_rdata=mem_rdata; next state IDLE.
- SERVE_D:
  - mem_read=!req_is_write, mem_write=req_is_write.
  - On mem_resp: d_resp=1 same cycle; d_rdata=mem_rdata on a read (don't-care on a write); next state IDLE.
- i_rdata/d_rdata: wired to mem_rdata permanently. Only valid when the matching resp is high.
- resp outputs: never asserted outside the matching SERVE state.
- mem_resp in IDLE (spurious, or left over from before a reset): ignored.
- Turnaround: one mandatory IDLE cycle between transactions. Requesters deassert in the cycle after resp, so a stale request is never re-granted.
- d_read and d_write both high: treated as a writeback (write wins).
- Reset mid-transaction: state returns to IDLE and the mem_* strobes drop the following cycle. The in-flight memory response is discarded; no resp is issued.
- Starvation bound: with both sides requesting continuously, grants strictly alternate.

Decomposition:
- Shared package: arb_state_t enum (IDLE, SERVE_I, SERVE_D) and the arb_side_t (I, D) type for last_grant. Add to rv32i_types or a new arb_types package.
- No sub-module: one FSM plus a latch register set. Optional helper rr_pick2 (2-way round-robin pick) only if reused by the L2 arbiter.

Test Plan:
1. I-only:
   - Stimulus: i_read=1, i_addr=0x0000_0040; memory responds 3 cycles after mem_read with rdata=0xA5..A5.
   - Response: mem_read rises 1 cycle after request, mem_addr=0x40; i_resp pulses exactly 1 cycle with i_rdata=0xA5..A5; d_resp stays 0.
2. D writeback:
   - Stimulus: d_write=1, d_addr=0x0000_1000, d_wdata=0x1234..; after grant, change d_addr to 0xFFFF_FFE0.
   - Response: mem_write=1 throughout, mem_addr stays 0x1000, mem_wdata=0x1234..; d_resp pulse at mem_resp.
3. Tie after reset:
   - Stimulus: i_read and d_read both high the first cycle after rst.
   - Response: I granted first; D granted in the first IDLE after i_resp. Keep both requests high for 4 transactions: grant order I,D,I,D.
4. Read and write together:
   - Stimulus: d_read=1 and d_write=1 simultaneously.
   - Response: mem_write=1, mem_read=0.
5. Reset mid-operation:
   - Stimulus: assert rst during SERVE_D, before mem_resp; memory then returns mem_resp.
   - Response: mem_read/mem_write drop the cycle after rst; no d_resp is issued; state is IDLE.
6. Spurious response:
   - Stimulus: pulse mem_resp while IDLE with no requests.
   - Response: i_resp=d_resp=0; state stays IDLE.
